vga_frame_swap_ctrl: RTL and testbench

- Sequences double-buffered frame presentation for the VGA subsystem's pixel DMA. It masters the pixel DMA control slave (2-bit word address, 32-bit data).
- After reset it programs buffer 0 as the front buffer. On each requester swap request it loads the other buffer as back buffer, triggers the swap, then polls status until the swap retires at vertical sync.
- Sits between the NPU/host display logic and the VGA_Subsystem pixel DMA control port.

---
 rtl/vga_ctrl_pkg.sv | 24 ++
 rtl/vga_frame_swap_ctrl.sv | 151 +++++++++++++++
 tb/tb_vga_frame_swap_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the VGA pixel-DMA frame swap controller:
// FSM state encoding and pixel DMA control-slave register map.
package vga_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT_WB  = 4'd0,
    ST_IDLE     = 4'd1,
    ST_WR_BACK  = 4'd2,
    ST_WR_SWAP  = 4'd3,
    ST_POLL_RD  = 4'd4,
    ST_POLL_CHK = 4'd5,
    ST_POLL_GAP = 4'd6,
    ST_DONE     = 4'd7,
    ST_DONE_ERR = 4'd8
  } state_t;

  localparam logic [1:0] REG_BUFFER  = 2'd0;
  localparam logic [1:0] REG_BACKBUF = 2'd1;
  localparam logic [1:0] REG_RES     = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int STATUS_SWAP_BIT = 0;

endpackage

// File: rtl/vga_frame_swap_ctrl.sv
// Double-buffer swap sequencer mastering the pixel DMA control slave.
// Bus handshake: single-cycle read/write strobes, no waitrequest; read data is valid the cycle after ctl_read.
module vga_frame_swap_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter logic [31:0] BUF0_ADDR      = 32'h0000_0000,
  parameter logic [31:0] BUF1_ADDR      = 32'h0004_B000,
  parameter int          POLL_GAP       = 16,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        sys_clk_clk,
  input  logic        sys_reset_reset,
  input  logic        swap_req,
  output logic        swap_done,
  output logic        ready,
  output logic        front_idx,
  output logic [31:0] back_addr,
  output logic        err_timeout,
  output logic [1:0]  ctl_address,
  output logic [3:0]  ctl_byteenable,
  output logic        ctl_read,
  output logic        ctl_write,
  output logic [31:0] ctl_writedata,
  input  logic [31:0] ctl_readdata,
  output state_t      dbg_state
);

  localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYCLES);
  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_target;
  logic        r_front_idx;
  logic        r_err_timeout;
  logic [31:0] r_to_cnt;
  logic [15:0] r_gap_cnt;

  logic        w_ctl_write;
  logic        w_ctl_read;
  logic [1:0]  w_ctl_address;
  logic [31:0] w_ctl_writedata;
  logic        w_swap_done;
  logic        w_ready;
  logic        w_status_pending;
  logic        w_timed_out;
  logic        w_polling;
  logic        w_unused_rdata;

  assign w_status_pending = ctl_readdata[STATUS_SWAP_BIT];
  assign w_unused_rdata   = ^ctl_readdata[31:1];
  assign w_timed_out      = (r_to_cnt >= TO_LIM);
  assign w_polling        = (r_state == ST_POLL_RD) || (r_state == ST_POLL_CHK) ||
                            (r_state == ST_POLL_GAP);

  always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
    if (sys_reset_reset) r_state <= ST_INIT_WB;
    else                 r_state <= w_next_state;
  end

  always_comb begin
    w_next_state    = r_state;
    w_ctl_write     = 1'b0;
    w_ctl_read      = 1'b0;
    w_ctl_address   = REG_BUFFER;
    w_ctl_writedata = '0;
    w_swap_done     = 1'b0;
    w_ready         = 1'b0;
    case (r_state)
      ST_INIT_WB: begin
        w_ctl_write     = 1'b1;
        w_ctl_address   = REG_BACKBUF;
        w_ctl_writedata = BUF0_ADDR;
        w_next_state    = ST_WR_SWAP;
      end
      ST_IDLE: begin
        w_ready = 1'b1;
        if (swap_req) w_next_state = ST_WR_BACK;
      end
      ST_WR_BACK: begin
        w_ctl_write     = 1'b1;
        w_ctl_address   = REG_BACKBUF;
        w_ctl_writedata = r_target ? BUF1_ADDR : BUF0_ADDR;
        w_next_state    = ST_WR_SWAP;
      end
      ST_WR_SWAP: begin
        w_ctl_write   = 1'b1;
        w_ctl_address = REG_BUFFER;
        w_next_state  = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        w_ctl_read    = 1'b1;
        w_ctl_address = REG_STATUS;
        w_next_state  = ST_POLL_CHK;
      end
      ST_POLL_CHK: begin
        if (!w_status_pending) w_next_state = ST_DONE;
        else if (w_timed_out)  w_next_state = ST_DONE_ERR;
        else                   w_next_state = ST_POLL_GAP;
      end
      ST_POLL_GAP: begin
        if (r_gap_cnt == 16'd0) w_next_state = ST_POLL_RD;
      end
      ST_DONE, ST_DONE_ERR: begin
        w_swap_done  = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_INIT_WB;
    endcase
  end

  // Datapath registers; the FSM state decides which of them move.
  always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
    if (sys_reset_reset) begin
      r_target      <= 1'b0;
      r_front_idx   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
    end else begin
      if (w_polling && (r_to_cnt != '1)) r_to_cnt <= r_to_cnt + 32'd1;
      case (r_state)
        ST_INIT_WB: r_target <= 1'b0;
        ST_IDLE:    if (swap_req) r_target <= ~r_front_idx;
        ST_WR_SWAP: r_to_cnt <= '0;
        ST_POLL_CHK: begin
          if (w_status_pending && w_timed_out) r_err_timeout <= 1'b1;
          r_gap_cnt <= GAP_LOAD;
        end
        ST_POLL_GAP: if (r_gap_cnt != 16'd0) r_gap_cnt <= r_gap_cnt - 16'd1;
        ST_DONE:    r_front_idx <= r_target;
        default: ;
      endcase
    end
  end

  // The reset state is INIT_WB, which decodes to a write; gate the bus and
  // handshake outputs so they read as idle for as long as reset is held.
  assign ctl_write      = w_ctl_write & ~sys_reset_reset;
  assign ctl_read       = w_ctl_read & ~sys_reset_reset;
  assign ctl_address    = sys_reset_reset ? 2'd0 : w_ctl_address;
  assign ctl_writedata  = sys_reset_reset ? 32'd0 : w_ctl_writedata;
  assign ctl_byteenable = (ctl_write | ctl_read) ? 4'hF : 4'h0;
  assign swap_done      = w_swap_done & ~sys_reset_reset;
  assign ready          = w_ready & ~sys_reset_reset;
  assign front_idx      = r_front_idx;
  assign back_addr      = r_front_idx ? BUF0_ADDR : BUF1_ADDR;
  assign err_timeout    = r_err_timeout;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_vga_frame_swap_ctrl.sv
// Directed bench for vga_frame_swap_ctrl: a status-register slave model,
// a bus access log compared against an expected queue, and a final report.
module tb_vga_frame_swap_ctrl;
  import vga_ctrl_pkg::*;

  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0004_B000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        swap_req = 1'b0;
  logic        swap_done, ready, front_idx, err_timeout, ctl_read, ctl_write;
  logic [31:0] back_addr, ctl_writedata;
  logic [31:0] ctl_readdata = '0;
  logic [1:0]  ctl_address;
  logic [3:0]  ctl_byteenable;
  state_t      dbg_state;

  vga_frame_swap_ctrl #(
    .BUF0_ADDR(B0), .BUF1_ADDR(B1), .POLL_GAP(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .sys_clk_clk(clk), .sys_reset_reset(rst), .swap_req(swap_req),
    .swap_done(swap_done), .ready(ready), .front_idx(front_idx),
    .back_addr(back_addr), .err_timeout(err_timeout),
    .ctl_address(ctl_address), .ctl_byteenable(ctl_byteenable),
    .ctl_read(ctl_read), .ctl_write(ctl_write), .ctl_writedata(ctl_writedata),
    .ctl_readdata(ctl_readdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stat_cfg = 0;
  int cfg_gen = 0;
  int seen_gen = 0;
  int rd_seen = 0;
  int cyc = 0;
  int done_cnt = 0;
  int overlap = 0;
  int be_bad = 0;

  logic [35:0] log_q[$];
  logic [35:0] exp_q[$];
  int          rd_cyc_q[$];

  // Slave model: the first stat_cfg reads after each reconfiguration report pending.
  always @(posedge clk) begin
    int n;
    n = (cfg_gen != seen_gen) ? 0 : rd_seen;
    seen_gen <= cfg_gen;
    ctl_readdata <= '0;
    if (ctl_read) begin
      ctl_readdata <= {31'd0, (n < stat_cfg)};
      n++;
    end
    rd_seen <= n;
  end

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ctl_write || ctl_read) log_q.push_back({ctl_write, ctl_read, ctl_address, ctl_writedata});
    if (ctl_read) rd_cyc_q.push_back(cyc);
    if (ctl_read && ctl_write) overlap <= overlap + 1;
    if ((ctl_read || ctl_write) != (ctl_byteenable == 4'hF)) be_bad <= be_bad + 1;
    if (ctl_byteenable != 4'h0 && ctl_byteenable != 4'hF) be_bad <= be_bad + 1;
    if (swap_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [35:0] wr(input logic [1:0] a, input logic [31:0] d);
    return {1'b1, 1'b0, a, d};
  endfunction

  function automatic logic [35:0] rd();
    return {1'b0, 1'b1, REG_STATUS, 32'd0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    logic [35:0] e, o;
    chk({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (log_q.size() > 0) ? log_q.pop_front() : 'x;
      chk(tag, 64'(o), 64'(e));
    end
    log_q.delete();
  endtask

  task automatic check_reads(input string tag, input int n);
    chk({tag, "_reads"}, 64'(rd_cyc_q.size()), 64'(n));
    for (int i = 1; i < rd_cyc_q.size(); i++)
      chk({tag, "_spacing"}, 64'(rd_cyc_q[i] - rd_cyc_q[i-1]), 64'd18);
    rd_cyc_q.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (swap_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(swap_done), 64'd1);
  endtask

  task automatic set_status(input int pending_reads);
    stat_cfg = pending_reads;
    cfg_gen++;
  endtask

  task automatic pulse_req();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write"}, 64'(ctl_write), 64'd0);
    chk({tag, "_read"}, 64'(ctl_read), 64'd0);
    chk({tag, "_addr"}, 64'(ctl_address), 64'd0);
    chk({tag, "_wdata"}, 64'(ctl_writedata), 64'd0);
    chk({tag, "_be"}, 64'(ctl_byteenable), 64'd0);
    chk({tag, "_done"}, 64'(swap_done), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_front"}, 64'(front_idx), 64'd0);
    chk({tag, "_err"}, 64'(err_timeout), 64'd0);
    chk({tag, "_back"}, 64'(back_addr), 64'(B1));
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_INIT_WB));
  endtask

  initial begin
    int d0;
    set_status(2);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // init: write backbuf=BUF0, swap, three status reads
    rst = 1'b0;
    exp_q.push_back(wr(REG_BACKBUF, B0));
    exp_q.push_back(wr(REG_BUFFER, 32'd0));
    repeat (3) exp_q.push_back(rd());
    wait_done("init", 200);
    chk("init_ready_in_done", 64'(ready), 64'd0);
    @(negedge clk);
    chk("init_ready", 64'(ready), 64'd1);
    chk("init_front", 64'(front_idx), 64'd0);
    chk("init_back", 64'(back_addr), 64'(B1));
    chk("init_done_width", 64'(swap_done), 64'd0);
    check_log("init_log");
    check_reads("init", 3);

    // swap to buffer 1, status clears on first poll
    set_status(0);
    pulse_req();
    chk("sw1_ready_drop", 64'(ready), 64'd0);
    exp_q.push_back(wr(REG_BACKBUF, B1));
    exp_q.push_back(wr(REG_BUFFER, 32'd0));
    exp_q.push_back(rd());
    wait_done("sw1", 100);
    chk("sw1_front_in_done", 64'(front_idx), 64'd0);
    @(negedge clk);
    chk("sw1_front", 64'(front_idx), 64'd1);
    chk("sw1_back", 64'(back_addr), 64'(B0));
    chk("sw1_ready", 64'(ready), 64'd1);
    check_log("sw1_log");
    check_reads("sw1", 1);

    // swap back to buffer 0
    pulse_req();
    exp_q.push_back(wr(REG_BACKBUF, B0));
    exp_q.push_back(wr(REG_BUFFER, 32'd0));
    exp_q.push_back(rd());
    wait_done("sw2", 100);
    @(negedge clk);
    chk("sw2_front", 64'(front_idx), 64'd0);
    chk("sw2_back", 64'(back_addr), 64'(B1));
    check_log("sw2_log");
    check_reads("sw2", 1);

    // status pending for 5 reads: 6 reads, 18 cycles apart
    set_status(5);
    pulse_req();
    exp_q.push_back(wr(REG_BACKBUF, B1));
    exp_q.push_back(wr(REG_BUFFER, 32'd0));
    repeat (6) exp_q.push_back(rd());
    wait_done("gap", 300);
    @(negedge clk);
    chk("gap_front", 64'(front_idx), 64'd1);
    chk("gap_err", 64'(err_timeout), 64'd0);
    check_log("gap_log");
    check_reads("gap", 6);

    // stuck status: poll counts 1,19,..,109 -> timeout on the 7th read
    set_status(1000);
    pulse_req();
    exp_q.push_back(wr(REG_BACKBUF, B0));
    exp_q.push_back(wr(REG_BUFFER, 32'd0));
    repeat (7) exp_q.push_back(rd());
    wait_done("to", 400);
    chk("to_err_in_done", 64'(err_timeout), 64'd1);
    @(negedge clk);
    chk("to_front", 64'(front_idx), 64'd1);
    chk("to_back", 64'(back_addr), 64'(B0));
    chk("to_ready", 64'(ready), 64'd1);
    chk("to_err_sticky", 64'(err_timeout), 64'd1);
    check_log("to_log");
    check_reads("to", 7);

    // asynchronous reset while waiting in the poll gap
    pulse_req();
    exp_q.push_back(wr(REG_BACKBUF, B0));
    exp_q.push_back(wr(REG_BUFFER, 32'd0));
    exp_q.push_back(rd());
    repeat (8) @(negedge clk);
    chk("pre_rst_state", 64'(dbg_state), 64'(ST_POLL_GAP));
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    check_log("async_rst_log");
    rd_cyc_q.delete();
    set_status(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(wr(REG_BACKBUF, B0));
    exp_q.push_back(wr(REG_BUFFER, 32'd0));
    exp_q.push_back(rd());
    wait_done("replay", 100);
    @(negedge clk);
    chk("replay_front", 64'(front_idx), 64'd0);
    chk("replay_ready", 64'(ready), 64'd1);
    chk("replay_err", 64'(err_timeout), 64'd0);
    check_log("replay_log");
    rd_cyc_q.delete();

    // swap_req held: three back-to-back swaps
    d0 = done_cnt;
    swap_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(wr(REG_BACKBUF, (i % 2 == 0) ? B1 : B0));
      exp_q.push_back(wr(REG_BUFFER, 32'd0));
      exp_q.push_back(rd());
      wait_done("b2b", 100);
      if (i == 2) swap_req = 1'b0;
      @(negedge clk);
      chk("b2b_front", 64'(front_idx), 64'((i % 2 == 0) ? 1 : 0));
    end
    chk("b2b_ready", 64'(ready), 64'd1);
    repeat (5) @(negedge clk);
    chk("b2b_done_cnt", 64'(done_cnt - d0), 64'd3);
    chk("b2b_idle", 64'(dbg_state), 64'(ST_IDLE));
    check_log("b2b_log");
    rd_cyc_q.delete();
    chk("strobe_overlap", 64'(overlap), 64'd0);
    chk("byteenable", 64'(be_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
